// File: rtl/regfile_dump_reader_pkg.sv
// Shared types and sizing for the register-file debug dump reader.
package regfile_dump_reader_pkg;

  // Register value width, architectural register count and index width.
  // ADDR_WIDTH must cover NUM_REGS (2**ADDR_WIDTH >= NUM_REGS).
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned ADDR_WIDTH = 5;

  // Reader sequencing: IDLE -> ADDR -> SEND -> (ADDR ...) -> FINISH -> IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } dump_state_t;

  // One streamed beat: register value, its index and end-of-request flag.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] index;
    logic                  last;
  } dump_beat_t;

  // A beat ends the request for a peek, or at the top architectural register.
  function automatic logic is_last_beat(input logic                  single,
                                        input logic [ADDR_WIDTH-1:0] idx);
    return single || (idx == ADDR_WIDTH'(NUM_REGS - 1));
  endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Register-file debug read port plus the valid/ready output beat stream.
interface regfile_dump_reader_if;
  import regfile_dump_reader_pkg::*;

  logic [ADDR_WIDTH-1:0] rf_rd_addr;
  logic [DATA_WIDTH-1:0] rf_rd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_index;
  logic                  out_last;

  // Reader side: drives the read address and the beat stream.
  modport master (
    output rf_rd_addr,
    input  rf_rd_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_index,
    output out_last
  );

  // Register file / consumer side.
  modport slave (
    input  rf_rd_addr,
    output rf_rd_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_index,
    input  out_last
  );

endinterface

// File: rtl/regfile_dump_reader.sv
// Walks the register-file debug read port and streams each value out,
// either a full x0..x(NUM_REGS-1) dump or a single-register peek.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic                   single_mode_i,
  input  logic [ADDR_WIDTH-1:0]  single_addr_i,
  output logic                   busy_o,
  output logic                   done_o,
  regfile_dump_reader_if.master  bus
);

  dump_state_t           state_q,  state_d;
  logic [ADDR_WIDTH-1:0] index_q,  index_d;
  logic                  single_q, single_d;
  dump_beat_t            beat_q,   beat_d;
  logic                  valid_q,  valid_d;
  logic                  busy_q,   busy_d;
  logic                  done_q,   done_d;
  logic                  accept_c;

  // Beat handed over at the coming edge.
  assign accept_c = valid_q && bus.out_ready;

  // Next-state, index walk and output holding register update.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    single_d = single_q;
    beat_d   = beat_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          single_d = single_mode_i;
          index_d  = single_mode_i ? single_addr_i : '0;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        // Read data is combinational off index_q; it is captured here so a
        // falling-edge write earlier in this cycle is included.
        beat_d.data  = bus.rf_rd_data;
        beat_d.index = index_q;
        beat_d.last  = is_last_beat(single_q, index_q);
        state_d      = SEND;
      end
      SEND: begin
        if (accept_c) begin
          if (beat_q.last) begin
            state_d = FINISH;
          end else begin
            index_d = index_q + ADDR_WIDTH'(1);
            state_d = ADDR;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered alongside the state they describe.
    valid_d = (state_d == SEND);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FINISH);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      index_q  <= '0;
      single_q <= 1'b0;
      beat_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      single_q <= single_d;
      beat_q   <= beat_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.rf_rd_addr = index_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_data   = beat_q.data;
  assign bus.out_index  = beat_q.index;
  assign bus.out_last   = beat_q.last;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader with a falling-edge-write regfile model.
module tb_regfile_dump_reader;
  import regfile_dump_reader_pkg::*;

  logic                  clk;
  logic                  reset;
  logic                  start;
  logic                  single_mode;
  logic [ADDR_WIDTH-1:0] single_addr;
  logic                  busy;
  logic                  done;

  regfile_dump_reader_if bus();

  regfile_dump_reader dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start),
    .single_mode_i (single_mode),
    .single_addr_i (single_addr),
    .busy_o        (busy),
    .done_o        (done),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: combinational read.
  logic [DATA_WIDTH-1:0] rf [NUM_REGS];
  assign bus.rf_rd_data = rf[bus.rf_rd_addr];

  int vectors    = 0;
  int miscompares = 0;

  dump_beat_t obs_q[$];
  dump_beat_t exp_q[$];
  int done_cnt, done_cyc, first_valid_cyc, last_acc_cyc, stall_viol, beats_acc;
  bit timed_out, wrote7;

  function automatic logic [DATA_WIDTH-1:0] exp_val(input int i);
    if (i == 2) return 32'h7FFF_F000;
    if (i == 5) return 32'h1234_5678;
    return DATA_WIDTH'(i * 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_full_exp(input logic [DATA_WIDTH-1:0] v7);
    for (int i = 0; i < int'(NUM_REGS); i++)
      exp_q.push_back('{data: (i == 7) ? v7 : exp_val(i),
                        index: ADDR_WIDTH'(i),
                        last: (i == int'(NUM_REGS) - 1)});
  endtask

  // Issues one request and records accepted beats and timing (cycle 0 = start high).
  task automatic run_request(input bit single, input logic [ADDR_WIDTH-1:0] addr,
                             input int ready_mode, input bit spam, input bit wr7,
                             input int max_cycles);
    dump_beat_t cur, prev;
    bit prev_pend, seen_done;
    int stall;
    obs_q.delete();
    done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; last_acc_cyc = -1;
    stall_viol = 0; beats_acc = 0; timed_out = 0; wrote7 = 0;
    prev_pend = 0; seen_done = 0; stall = 0; prev = '0;
    single_mode = single;
    single_addr = addr;
    for (int cyc = 0; ; cyc++) begin
      if (seen_done) begin start = 1'b0; break; end
      if (cyc >= max_cycles) begin timed_out = 1; start = 1'b0; break; end
      start = (cyc == 0) || spam;
      if (ready_mode == 1) begin
        if (beats_acc == 3 && stall < 7) begin bus.out_ready = 1'b0; stall++; end
        else if (beats_acc >= 3) bus.out_ready = ((cyc % 2) == 1);
        else bus.out_ready = 1'b1;
      end else begin
        bus.out_ready = 1'b1;
      end
      cur = '{data: bus.out_data, index: bus.out_index, last: bus.out_last};
      if (bus.out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (prev_pend && cur !== prev) stall_viol++;
      end
      if (bus.out_valid && bus.out_ready) begin
        obs_q.push_back(cur);
        beats_acc++;
        last_acc_cyc = cyc;
        prev_pend = 0;
      end else begin
        prev_pend = bus.out_valid;
        prev = cur;
      end
      if (done) begin done_cnt++; done_cyc = cyc; seen_done = 1; end
      // ADDR cycle for x7: write on the falling edge inside it.
      if (wr7 && !wrote7 && busy && !bus.out_valid && !done && bus.rf_rd_addr == 7) begin
        @(negedge clk);
        rf[7] = 32'hDEAD_BEEF;
        wrote7 = 1;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b required 0", bus.out_valid); end
    vectors++; if (bus.out_data !== '0) begin miscompares++; $display("FAIL reset_out_data got %h required 0", bus.out_data); end
    vectors++; if (bus.out_index !== '0) begin miscompares++; $display("FAIL reset_out_index got %0d required 0", bus.out_index); end
    vectors++; if (bus.out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last got %b required 0", bus.out_last); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL reset_busy_done got %b%b required 00", busy, done); end
    vectors++; if (bus.rf_rd_addr !== '0) begin miscompares++; $display("FAIL reset_rf_rd_addr got %0d required 0", bus.rf_rd_addr); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_full_dump();
    dump_beat_t got, want;
    exp_q.delete();
    push_full_exp(exp_val(7));
    run_request(1'b0, '0, 0, 1'b0, 1'b0, 200);
    vectors++; if (timed_out) begin miscompares++; $display("FAIL full_timeout got timeout required done"); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front(); vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL full_extra_beat got idx=%0d data=%h required none", got.index, got.data); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin miscompares++; $display("FAIL full_beat got idx=%0d data=%h last=%b required idx=%0d data=%h last=%b", got.index, got.data, got.last, want.index, want.data, want.last); end
      end
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL full_missing got %0d left required 0", exp_q.size()); end
    vectors++; if (first_valid_cyc != 2) begin miscompares++; $display("FAIL full_first_latency got %0d required 2", first_valid_cyc); end
    vectors++; if (last_acc_cyc != 64) begin miscompares++; $display("FAIL full_last_accept got %0d required 64", last_acc_cyc); end
    vectors++; if (done_cyc != last_acc_cyc + 1) begin miscompares++; $display("FAIL full_done_cycle got %0d required %0d", done_cyc, last_acc_cyc + 1); end
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL full_after_done got done=%b busy=%b required 0 0", done, busy); end
  endtask

  task automatic test_single();
    dump_beat_t got, want;
    exp_q.delete();
    exp_q.push_back('{data: 32'h1234_5678, index: ADDR_WIDTH'(5), last: 1'b1});
    run_request(1'b1, ADDR_WIDTH'(5), 0, 1'b0, 1'b0, 50);
    vectors++; if (timed_out) begin miscompares++; $display("FAIL single_timeout got timeout required done"); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front(); vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL single_extra_beat got idx=%0d data=%h required none", got.index, got.data); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin miscompares++; $display("FAIL single_beat got idx=%0d data=%h last=%b required idx=%0d data=%h last=%b", got.index, got.data, got.last, want.index, want.data, want.last); end
      end
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL single_missing got %0d left required 0", exp_q.size()); end
    vectors++; if (first_valid_cyc != 2) begin miscompares++; $display("FAIL single_latency got %0d required 2", first_valid_cyc); end
    vectors++; if (done_cyc != 3) begin miscompares++; $display("FAIL single_done_cycle got %0d required 3", done_cyc); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_after_done got %b required 0", busy); end
  endtask

  task automatic test_backpressure();
    dump_beat_t got, want;
    exp_q.delete();
    push_full_exp(exp_val(7));
    run_request(1'b0, '0, 1, 1'b0, 1'b0, 400);
    vectors++; if (timed_out) begin miscompares++; $display("FAIL bp_timeout got timeout required done"); end
    vectors++; if (stall_viol != 0) begin miscompares++; $display("FAIL bp_stable got %0d changes required 0", stall_viol); end
    vectors++; if (beats_acc != int'(NUM_REGS)) begin miscompares++; $display("FAIL bp_beat_count got %0d required %0d", beats_acc, NUM_REGS); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front(); vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL bp_extra_beat got idx=%0d data=%h required none", got.index, got.data); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin miscompares++; $display("FAIL bp_beat got idx=%0d data=%h last=%b required idx=%0d data=%h last=%b", got.index, got.data, got.last, want.index, want.data, want.last); end
      end
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL bp_missing got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_start_spam();
    int extra;
    run_request(1'b0, '0, 0, 1'b1, 1'b0, 200);
    vectors++; if (timed_out) begin miscompares++; $display("FAIL spam_timeout got timeout required done"); end
    vectors++; if (beats_acc != int'(NUM_REGS)) begin miscompares++; $display("FAIL spam_beat_count got %0d required %0d", beats_acc, NUM_REGS); end
    vectors++; if (last_acc_cyc != 64) begin miscompares++; $display("FAIL spam_last_accept got %0d required 64", last_acc_cyc); end
    // start was high during FINISH; no new request may follow.
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      if (busy || bus.out_valid || done) extra++;
      tick();
    end
    vectors++; if (extra != 0) begin miscompares++; $display("FAIL spam_restart got %0d busy cycles required 0", extra); end
  endtask

  task automatic test_reset_mid();
    dump_beat_t got, want;
    bit found;
    int stray;
    found = 0;
    single_mode = 1'b0;
    bus.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bus.out_valid && bus.out_index == 10) begin found = 1; break; end
      bus.out_ready = 1'b1;
      tick();
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL rstmid_reach_beat10 got not reached required reached"); end
    bus.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    vectors++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL rstmid_outputs got valid=%b busy=%b done=%b required 0 0 0", bus.out_valid, busy, done); end
    vectors++; if (bus.out_index !== '0 || bus.out_data !== '0 || bus.rf_rd_addr !== '0) begin miscompares++; $display("FAIL rstmid_regs got idx=%0d data=%h addr=%0d required 0 0 0", bus.out_index, bus.out_data, bus.rf_rd_addr); end
    reset = 1'b0;
    stray = 0;
    for (int c = 0; c < 3; c++) begin
      if (done || bus.out_valid) stray++;
      tick();
    end
    vectors++; if (stray != 0) begin miscompares++; $display("FAIL rstmid_stray_done got %0d required 0", stray); end
    exp_q.delete();
    push_full_exp(exp_val(7));
    run_request(1'b0, '0, 0, 1'b0, 1'b0, 200);
    vectors++; if (timed_out) begin miscompares++; $display("FAIL rstmid_timeout got timeout required done"); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front(); vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL rstmid_extra_beat got idx=%0d data=%h required none", got.index, got.data); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin miscompares++; $display("FAIL rstmid_beat got idx=%0d data=%h last=%b required idx=%0d data=%h last=%b", got.index, got.data, got.last, want.index, want.data, want.last); end
      end
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL rstmid_missing got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_concurrent_write();
    dump_beat_t got, want;
    exp_q.delete();
    push_full_exp(32'hDEAD_BEEF);
    run_request(1'b0, '0, 0, 1'b0, 1'b1, 200);
    vectors++; if (timed_out) begin miscompares++; $display("FAIL cw_timeout got timeout required done"); end
    vectors++; if (!wrote7) begin miscompares++; $display("FAIL cw_addr7_cycle got not seen required seen"); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front(); vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL cw_extra_beat got idx=%0d data=%h required none", got.index, got.data); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin miscompares++; $display("FAIL cw_beat got idx=%0d data=%h last=%b required idx=%0d data=%h last=%b", got.index, got.data, got.last, want.index, want.data, want.last); end
      end
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL cw_missing got %0d left required 0", exp_q.size()); end
    rf[7] = exp_val(7);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    single_mode = 1'b0;
    single_addr = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < int'(NUM_REGS); i++) rf[i] = exp_val(i);
    test_reset();
    test_full_dump();
    test_single();
    test_backpressure();
    test_start_spam();
    test_reset_mid();
    test_concurrent_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug reader for the CPU register file. It walks the register file's read port and streams each register value out over a valid/ready handshake.
- The consumer is the UART/MMIO display path.
- Two modes: full dump (x0..x31 in order) or single-register peek (e.g. index taken from board switches).
- Sits beside the core. It drives a dedicated debug read address and samples the returned combinational read data.

Parameters:
- DATA_WIDTH, 32, width of a register value.
- NUM_REGS, 32, number of architectural registers dumped.
- ADDR_WIDTH, 5, register index width; must satisfy 2^ADDR_WIDTH >= NUM_REGS.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- single_mode  in  1  latched at start: 1 = peek one register, 0 = full dump.
- single_addr  in  ADDR_WIDTH  register index to peek; latched at start.
- rf_rd_addr  out  ADDR_WIDTH  address driven to the register file debug read port.
- rf_rd_data  in  DATA_WIDTH  combinational read data returned for rf_rd_addr.
- out_valid  out  1  out_data/out_index/out_last hold a valid beat.
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready.
- out_data  out  DATA_WIDTH  captured register value.
- out_index  out  ADDR_WIDTH  index of the register in out_data.
- out_last  out  1  beat is the final one of this request.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset values:
  - state = IDLE, index = 0, rf_rd_addr = 0.
  - out_valid = 0, out_data = 0, out_index = 0, out_last = 0.
  - busy = 0, done = 0.
- rf_rd_addr is driven from the index register at all times.
- FSM states: IDLE, ADDR, SEND, FINISH.
- IDLE:
  - On start = 1, latch mode := single_mode.
  - Set index := single_addr if single, else 0.
  - Go to ADDR.
  - start in any other state is ignored (no queuing).
- ADDR:
  - One cycle with rf_rd_addr stable.
  - At the rising edge ending ADDR, capture out_data := rf_rd_data and out_index := index.
  - Compute out_last := single || (index == NUM_REGS-1).
  - Go to SEND.
- SEND:
  - out_valid = 1. out_data, out_index and out_last are held stable until accepted.
  - On out_valid && out_ready:
    - If out_last, go to FINISH.
    - Otherwise index := index+1 and go to ADDR.
  - out_valid deasserts the cycle after acceptance.
- FINISH:
  - done = 1 for exactly one cycle, then go to IDLE.
  - start in FINISH is ignored.
- Latency:
  - start high in cycle N → out_valid high in cycle N+2.
  - Each subsequent beat arrives 2 cycles after the previous acceptance, provided out_ready is held high.
  - Full dump with out_ready tied high: 64 cycles from start to last acceptance, then done.
- Index arithmetic:
  - index increments within ADDR_WIDTH bits.
  - Termination compares against NUM_REGS-1, so there is never a wrap to 0.
  - single_addr >= NUM_REGS (only possible if NUM_REGS < 2^ADDR_WIDTH) is passed through unchanged; the result is whatever the port returns.
- Register values are passed through verbatim.
  - x0 is reported as read: it reads 0.
  - No value filtering.
- Concurrency:
  - The register file writes on the falling clock edge. The value captured is the one present at the capturing rising edge, so it includes a same-cycle write.
  - The dump is not an atomic snapshot; the core keeps running.
- Reset mid-operation:
  - Immediate return to IDLE, with all outputs at their reset values.
  - A pending beat is dropped and no done is issued.
- Backpressure:
  - out_ready low for an arbitrary number of cycles stalls in SEND.
  - No beat is lost or duplicated.

Decomposition:
- Shared package:
  - dump_state_t enum {IDLE, ADDR, SEND, FINISH}.
  - DATA_WIDTH and register-count constants, alongside the existing data-width constant in the shared constants header.
- No sub-module is warranted. Single FSM plus one output holding register; target 120-200 lines.

Test Plan:
- Full dump, out_ready = 1, register-file model with x2 = 0x7FFF_F000, x5 = 0x1234_5678, others = index*4 → 32 beats with out_index 0..31.
  - Beat 2 = 0x7FFF_F000, beat 5 = 0x1234_5678, beat 0 = 0.
  - out_last only on index 31; done exactly once, 1 cycle after the last acceptance.
- Single mode, single_addr = 5 → exactly one beat: out_index = 5, out_data = 0x1234_5678, out_last = 1.
  - First out_valid exactly 2 cycles after start; busy falls after the done pulse.
- Backpressure: out_ready low for 7 cycles on beat 3, then toggle 1/0 → out_data and out_index stable while stalled.
  - Sequence is still 0..31 with no duplicates; total beats = 32.
- Start spam: pulse start every cycle during a full dump → only one dump occurs; start asserted in FINISH is ignored.
- Reset at beat 10 while out_valid = 1 → next cycle out_valid = 0, busy = 0, done = 0.
  - A fresh start then dumps from index 0.
- Concurrent write: model writes x7 = 0xDEAD_BEEF on the falling edge inside the ADDR cycle for index 7 → beat 7 reports 0xDEAD_BEEF.
